vx_icache_stage: RTL and testbench

- Fetch-side stage that sits directly upstream of the icache request interface and directly downstream of the warp scheduler.
- Accepts per-warp fetch requests (wid, PC, tmask) and issues icache core requests with tag = wid.
- Holds per-warp PC/tmask metadata while the request is outstanding.
- Joins icache responses with that metadata to produce the ifetch output to decode.

---
 rtl/vx_icache_stage.sv | 110 +++++++++++
 tb/tb_vx_icache_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_icache_stage.sv
// vx_icache_stage: issues per-warp icache fetches and joins responses with held PC/tmask metadata
module vx_icache_stage #(
   parameter int NUM_WARPS       = 4,
   parameter int NUM_THREADS     = 4,
   parameter int WORD_ADDR_WIDTH = 30,
   localparam int TAG_WIDTH      = $clog2(NUM_WARPS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sched_valid,
   input  logic [TAG_WIDTH-1:0]       sched_wid,
   input  logic [31:0]                sched_pc,
   input  logic [NUM_THREADS-1:0]     sched_tmask,
   output logic                       sched_ready,
   output logic                       icache_req_valid,
   output logic [WORD_ADDR_WIDTH-1:0] icache_req_addr,
   output logic [TAG_WIDTH-1:0]       icache_req_tag,
   input  logic                       icache_req_ready,
   input  logic                       icache_rsp_valid,
   input  logic [31:0]                icache_rsp_data,
   input  logic [TAG_WIDTH-1:0]       icache_rsp_tag,
   output logic                       icache_rsp_ready,
   output logic                       ifetch_valid,
   output logic [TAG_WIDTH-1:0]       ifetch_wid,
   output logic [31:0]                ifetch_pc,
   output logic [NUM_THREADS-1:0]     ifetch_tmask,
   output logic [31:0]                ifetch_instr,
   input  logic                       ifetch_ready,
   output logic [NUM_WARPS-1:0]       pending_mask,
   output logic                       tag_err
);
   logic [31:0]                meta_pc [NUM_WARPS];
   logic [NUM_THREADS-1:0]     meta_tmask [NUM_WARPS];
   logic                       tail_valid;
   logic [TAG_WIDTH-1:0]       tail_tag;
   logic [WORD_ADDR_WIDTH-1:0] tail_addr;
   logic                       push, pop, rsp_fire, rsp_hit;
   logic [NUM_WARPS-1:0]       set_mask, clr_mask;

   // handshake qualifiers; both ready outputs are forced low while reset is held
   always_comb begin
      sched_ready      = !reset & !tail_valid & !pending_mask[sched_wid];
      icache_rsp_ready = !reset & (!ifetch_valid | ifetch_ready);
      push             = sched_valid & sched_ready;
      pop              = icache_req_valid & icache_req_ready;
      rsp_fire         = icache_rsp_valid & icache_rsp_ready;
      rsp_hit          = pending_mask[icache_rsp_tag];
      set_mask         = push ? NUM_WARPS'(1) << sched_wid : '0;
      clr_mask         = (rsp_fire & rsp_hit) ? NUM_WARPS'(1) << icache_rsp_tag : '0;
   end

   // two-entry request queue: head registers drive the icache port, tail fills only while head is stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icache_req_valid <= 1'b0;
         icache_req_addr  <= '0;
         icache_req_tag   <= '0;
         tail_valid       <= 1'b0;
         tail_addr        <= '0;
         tail_tag         <= '0;
      end else if (pop & tail_valid) begin
         icache_req_addr  <= tail_addr;
         icache_req_tag   <= tail_tag;
         tail_valid       <= 1'b0;
      end else if (pop | !icache_req_valid) begin
         icache_req_valid <= push;
         if (push) begin
            icache_req_addr <= sched_pc[31 -: WORD_ADDR_WIDTH];
            icache_req_tag  <= sched_wid;
         end
      end else if (push) begin
         tail_addr  <= sched_pc[31 -: WORD_ADDR_WIDTH];
         tail_tag   <= sched_wid;
         tail_valid <= 1'b1;
      end
   end

   // per-warp metadata captured on accept; a pending warp cannot be rewritten, so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         meta_pc[sched_wid]    <= sched_pc;
         meta_tmask[sched_wid] <= sched_tmask;
      end
   end

   // pending tracking, response join into the ifetch register, and sticky flag for unmatched tags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_mask <= '0;
         tag_err      <= 1'b0;
         ifetch_valid <= 1'b0;
         ifetch_wid   <= '0;
         ifetch_pc    <= '0;
         ifetch_tmask <= '0;
         ifetch_instr <= '0;
      end else begin
         pending_mask <= (pending_mask | set_mask) & ~clr_mask;
         tag_err      <= tag_err | (rsp_fire & !rsp_hit);
         if (rsp_fire & rsp_hit) begin
            ifetch_valid <= 1'b1;
            ifetch_wid   <= icache_rsp_tag;
            ifetch_pc    <= meta_pc[icache_rsp_tag];
            ifetch_tmask <= meta_tmask[icache_rsp_tag];
            ifetch_instr <= icache_rsp_data;
         end else if (ifetch_ready) begin
            ifetch_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vx_icache_stage.sv
// tb_vx_icache_stage: directed scenarios plus randomized traffic against a queue-based reference model
module tb_vx_icache_stage;
   localparam int NW = 4;
   localparam int NT = 4;
   localparam int AW = 30;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sched_valid = 1'b0;
   logic [TW-1:0] sched_wid = '0;
   logic [31:0]   sched_pc = '0;
   logic [NT-1:0] sched_tmask = '0;
   logic          sched_ready;
   logic          icache_req_valid;
   logic [AW-1:0] icache_req_addr;
   logic [TW-1:0] icache_req_tag;
   logic          icache_req_ready = 1'b0;
   logic          icache_rsp_valid = 1'b0;
   logic [31:0]   icache_rsp_data = '0;
   logic [TW-1:0] icache_rsp_tag = '0;
   logic          icache_rsp_ready;
   logic          ifetch_valid;
   logic [TW-1:0] ifetch_wid;
   logic [31:0]   ifetch_pc;
   logic [NT-1:0] ifetch_tmask;
   logic [31:0]   ifetch_instr;
   logic          ifetch_ready = 1'b1;
   logic [NW-1:0] pending_mask;
   logic          tag_err;

   int checks = 0;
   int errors = 0;
   logic [31:0]   m_pc [NW];
   logic [NT-1:0] m_tm [NW];

   vx_icache_stage #(.NUM_WARPS(NW), .NUM_THREADS(NT), .WORD_ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .sched_valid(sched_valid), .sched_wid(sched_wid), .sched_pc(sched_pc), .sched_tmask(sched_tmask),
      .sched_ready(sched_ready),
      .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
      .icache_req_ready(icache_req_ready),
      .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
      .icache_rsp_ready(icache_rsp_ready),
      .ifetch_valid(ifetch_valid), .ifetch_wid(ifetch_wid), .ifetch_pc(ifetch_pc), .ifetch_tmask(ifetch_tmask),
      .ifetch_instr(ifetch_instr), .ifetch_ready(ifetch_ready),
      .pending_mask(pending_mask), .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [TW-1:0] w, input logic [31:0] pc, input logic [NT-1:0] tm);
      sched_valid = 1'b1;
      sched_wid   = w;
      sched_pc    = pc;
      sched_tmask = tm;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      offer(2'd0, 32'h1234_5678, 4'hf);
      icache_rsp_valid = 1'b1;
      #2;
      checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL rst_sched_ready: got %b want 0", sched_ready); end
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", icache_req_valid); end
      checks++; if (icache_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready: got %b want 0", icache_rsp_ready); end
      checks++; if (ifetch_valid !== 1'b0) begin errors++; $display("FAIL rst_ifetch_valid: got %b want 0", ifetch_valid); end
      checks++; if (pending_mask !== 4'h0) begin errors++; $display("FAIL rst_pending: got %h want 0", pending_mask); end
      checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL rst_tag_err: got %b want 0", tag_err); end
      step();
      step();
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b0;
      reset = 1'b0;
      step();
      checks++; if (pending_mask !== 4'h0 || tag_err !== 1'b0) begin errors++; $display("FAIL rst_after: got pend=%h err=%b want 0/0", pending_mask, tag_err); end
   endtask

   task automatic test_backpressure();
      icache_req_ready = 1'b0;
      m_tm[1] = NT'($urandom);
      m_tm[2] = NT'($urandom);
      m_pc[1] = 32'h8000_0010;
      m_pc[2] = 32'h8000_0020;
      offer(2'd1, m_pc[1], m_tm[1]);
      #1;
      checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w1: got %b want 1", sched_ready); end
      step();
      offer(2'd2, m_pc[2], m_tm[2]);
      #1;
      checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w2: got %b want 1", sched_ready); end
      checks++; if (pending_mask !== 4'b0010) begin errors++; $display("FAIL bp_pend1: got %b want 0010", pending_mask); end
      checks++; if ({icache_req_valid, icache_req_tag, icache_req_addr} !== {1'b1, 2'd1, 30'h2000_0004}) begin errors++; $display("FAIL bp_head1: got v=%b tag=%0d addr=%h want 1/1/20000004", icache_req_valid, icache_req_tag, icache_req_addr); end
      step();
      offer(2'd3, 32'h8000_0030, 4'h1);
      #1;
      checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got sched_ready=%b want 0", sched_ready); end
      checks++; if (pending_mask !== 4'b0110) begin errors++; $display("FAIL bp_pend2: got %b want 0110", pending_mask); end
      step();
      sched_valid = 1'b0;
      checks++; if ({icache_req_valid, icache_req_tag, icache_req_addr} !== {1'b1, 2'd1, 30'h2000_0004}) begin errors++; $display("FAIL bp_hold: got v=%b tag=%0d addr=%h want 1/1/20000004", icache_req_valid, icache_req_tag, icache_req_addr); end
      icache_req_ready = 1'b1;
      step();
      checks++; if ({icache_req_valid, icache_req_tag, icache_req_addr} !== {1'b1, 2'd2, 30'h2000_0008}) begin errors++; $display("FAIL bp_head2: got v=%b tag=%0d addr=%h want 1/2/20000008", icache_req_valid, icache_req_tag, icache_req_addr); end
      step();
      icache_req_ready = 1'b0;
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", icache_req_valid); end
      checks++; if (pending_mask !== 4'b0110) begin errors++; $display("FAIL bp_pend3: got %b want 0110", pending_mask); end
   endtask

   task automatic test_ooo_join();
      ifetch_ready = 1'b1;
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd2;
      icache_rsp_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (icache_rsp_ready !== 1'b1) begin errors++; $display("FAIL ooo_rsp_ready: got %b want 1", icache_rsp_ready); end
      step();
      icache_rsp_tag = 2'd1;
      icache_rsp_data = 32'h0000_0013;
      checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {1'b1, 2'd2, m_pc[2], m_tm[2], 32'hDEAD_BEEF}) begin errors++; $display("FAIL ooo_first: got v=%b w=%0d pc=%h tm=%h i=%h want 1/2/%h/%h/deadbeef", ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, m_pc[2], m_tm[2]); end
      checks++; if (pending_mask !== 4'b0010) begin errors++; $display("FAIL ooo_pend1: got %b want 0010", pending_mask); end
      step();
      icache_rsp_valid = 1'b0;
      checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {1'b1, 2'd1, m_pc[1], m_tm[1], 32'h0000_0013}) begin errors++; $display("FAIL ooo_second: got v=%b w=%0d pc=%h tm=%h i=%h want 1/1/%h/%h/00000013", ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, m_pc[1], m_tm[1]); end
      checks++; if (pending_mask !== 4'b0000) begin errors++; $display("FAIL ooo_pend2: got %b want 0000", pending_mask); end
      step();
      checks++; if (ifetch_valid !== 1'b0) begin errors++; $display("FAIL ooo_drain: got %b want 0", ifetch_valid); end
   endtask

   task automatic test_pending_stall();
      logic [31:0] d;
      d = $urandom;
      m_pc[0] = $urandom;
      m_tm[0] = NT'($urandom);
      icache_req_ready = 1'b1;
      offer(2'd0, m_pc[0], m_tm[0]);
      step();
      offer(2'd0, m_pc[0] ^ 32'h40, m_tm[0]);
      checks++; if ({icache_req_valid, icache_req_tag, icache_req_addr} !== {1'b1, 2'd0, m_pc[0][31:2]}) begin errors++; $display("FAIL stall_req: got v=%b tag=%0d addr=%h want 1/0/%h", icache_req_valid, icache_req_tag, icache_req_addr, m_pc[0][31:2]); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL stall_wait%0d: got sched_ready=%b want 0", i, sched_ready); end
         step();
      end
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd0;
      icache_rsp_data = d;
      #1;
      checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL stall_hs_cycle: got sched_ready=%b want 0", sched_ready); end
      step();
      icache_rsp_valid = 1'b0;
      checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got sched_ready=%b want 1", sched_ready); end
      checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {1'b1, 2'd0, m_pc[0], m_tm[0], d}) begin errors++; $display("FAIL stall_ifetch: got v=%b w=%0d pc=%h tm=%h i=%h want 1/0/%h/%h/%h", ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, m_pc[0], m_tm[0], d); end
      sched_valid = 1'b0;
      step();
      checks++; if (ifetch_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got ifv=%b reqv=%b want 0/0", ifetch_valid, icache_req_valid); end
   endtask

   task automatic test_ifetch_backpressure();
      logic [31:0] d1, d2;
      d1 = $urandom;
      d2 = $urandom;
      m_pc[1] = $urandom;
      m_tm[1] = NT'($urandom);
      m_pc[2] = $urandom;
      m_tm[2] = NT'($urandom);
      icache_req_ready = 1'b1;
      ifetch_ready = 1'b0;
      offer(2'd1, m_pc[1], m_tm[1]);
      step();
      offer(2'd2, m_pc[2], m_tm[2]);
      step();
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd1;
      icache_rsp_data = d1;
      step();
      icache_rsp_tag = 2'd2;
      icache_rsp_data = d2;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (icache_rsp_ready !== 1'b0) begin errors++; $display("FAIL ifbp_rsp_ready%0d: got %b want 0", i, icache_rsp_ready); end
         checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {1'b1, 2'd1, m_pc[1], m_tm[1], d1}) begin errors++; $display("FAIL ifbp_hold%0d: got v=%b w=%0d pc=%h tm=%h i=%h want 1/1/%h/%h/%h", i, ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, m_pc[1], m_tm[1], d1); end
         step();
      end
      ifetch_ready = 1'b1;
      #1;
      checks++; if (icache_rsp_ready !== 1'b1) begin errors++; $display("FAIL ifbp_release: got rsp_ready=%b want 1", icache_rsp_ready); end
      step();
      icache_rsp_valid = 1'b0;
      checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {1'b1, 2'd2, m_pc[2], m_tm[2], d2}) begin errors++; $display("FAIL ifbp_next: got v=%b w=%0d pc=%h tm=%h i=%h want 1/2/%h/%h/%h", ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, m_pc[2], m_tm[2], d2); end
      step();
      checks++; if (ifetch_valid !== 1'b0 || pending_mask !== 4'h0) begin errors++; $display("FAIL ifbp_drain: got ifv=%b pend=%b want 0/0000", ifetch_valid, pending_mask); end
   endtask

   task automatic test_random(input int n);
      logic [TW+AW-1:0] q[$];
      logic [TW-1:0]    issued[$];
      logic [NW-1:0]    pend;
      logic [TW+AW-1:0] hd;
      logic             ev, exp_sr, exp_rr, acc, pop, fire, done;
      logic [TW-1:0]    ew;
      logic [31:0]      epc, ei;
      logic [NT-1:0]    etm;
      int               idx;
      pend = '0;
      ev = 1'b0;
      ew = '0;
      epc = '0;
      ei = '0;
      etm = '0;
      done = 1'b0;
      for (int cyc = 0; cyc < n + 60; cyc++) begin
         logic drain;
         drain = cyc >= n;
         if (drain && q.size() == 0 && issued.size() == 0 && !ev) begin
            done = 1'b1;
            break;
         end
         sched_valid      = !drain && $urandom_range(0, 2) != 0;
         sched_wid        = TW'($urandom_range(0, NW - 1));
         sched_pc         = $urandom;
         sched_tmask      = NT'($urandom);
         icache_req_ready = drain || $urandom_range(0, 3) != 0;
         ifetch_ready     = drain || $urandom_range(0, 2) != 0;
         icache_rsp_valid = issued.size() != 0 && (drain || $urandom_range(0, 1) != 0);
         idx              = issued.size() != 0 ? int'($urandom_range(0, issued.size() - 1)) : 0;
         icache_rsp_tag   = issued.size() != 0 ? issued[idx] : '0;
         icache_rsp_data  = $urandom;
         #1;
         exp_sr = q.size() < 2 && !pend[sched_wid];
         exp_rr = !ev || ifetch_ready;
         checks++; if (sched_ready !== exp_sr) begin errors++; $display("FAIL rnd_sched_ready c%0d: got %b want %b", cyc, sched_ready, exp_sr); end
         checks++; if (icache_req_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_req_valid c%0d: got %b want %b", cyc, icache_req_valid, q.size() != 0); end
         if (q.size() != 0) begin
            hd = q[0];
            checks++; if ({icache_req_tag, icache_req_addr} !== hd) begin errors++; $display("FAIL rnd_req_head c%0d: got tag=%0d addr=%h want tag=%0d addr=%h", cyc, icache_req_tag, icache_req_addr, hd[TW+AW-1:AW], hd[AW-1:0]); end
         end
         checks++; if (icache_rsp_ready !== exp_rr) begin errors++; $display("FAIL rnd_rsp_ready c%0d: got %b want %b", cyc, icache_rsp_ready, exp_rr); end
         checks++; if (ifetch_valid !== ev) begin errors++; $display("FAIL rnd_ifetch_valid c%0d: got %b want %b", cyc, ifetch_valid, ev); end
         if (ev) begin
            checks++; if ({ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== {ew, epc, etm, ei}) begin errors++; $display("FAIL rnd_ifetch_data c%0d: got w=%0d pc=%h tm=%h i=%h want %0d/%h/%h/%h", cyc, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr, ew, epc, etm, ei); end
         end
         checks++; if (pending_mask !== pend) begin errors++; $display("FAIL rnd_pending c%0d: got %b want %b", cyc, pending_mask, pend); end
         checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL rnd_tag_err c%0d: got %b want 0", cyc, tag_err); end
         acc  = sched_valid && exp_sr;
         pop  = q.size() != 0 && icache_req_ready;
         fire = icache_rsp_valid && exp_rr;
         if (fire && pend[icache_rsp_tag]) begin
            ev  = 1'b1;
            ew  = icache_rsp_tag;
            epc = m_pc[icache_rsp_tag];
            etm = m_tm[icache_rsp_tag];
            ei  = icache_rsp_data;
            pend[icache_rsp_tag] = 1'b0;
         end else if (ifetch_ready) begin
            ev = 1'b0;
         end
         if (fire) issued.delete(idx);
         if (pop) begin
            hd = q.pop_front();
            issued.push_back(hd[TW+AW-1:AW]);
         end
         if (acc) begin
            q.push_back({sched_wid, sched_pc[31:2]});
            m_pc[sched_wid] = sched_pc;
            m_tm[sched_wid] = sched_tmask;
            pend[sched_wid] = 1'b1;
         end
         step();
      end
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b0;
      icache_req_ready = 1'b0;
      ifetch_ready = 1'b1;
      checks++; if (!done) begin errors++; $display("FAIL rnd_drain_timeout: got q=%0d issued=%0d want 0/0", q.size(), issued.size()); end
      checks++; if (pending_mask !== 4'h0 || ifetch_valid !== 1'b0) begin errors++; $display("FAIL rnd_final: got pend=%b ifv=%b want 0000/0", pending_mask, ifetch_valid); end
   endtask

   task automatic test_spurious_tag();
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd3;
      icache_rsp_data = 32'hBAD0_BAD0;
      #1;
      checks++; if (pending_mask !== 4'h0 || icache_rsp_ready !== 1'b1) begin errors++; $display("FAIL spur_pre: got pend=%b rsp_ready=%b want 0000/1", pending_mask, icache_rsp_ready); end
      step();
      icache_rsp_valid = 1'b0;
      checks++; if (ifetch_valid !== 1'b0) begin errors++; $display("FAIL spur_ifetch: got %b want 0", ifetch_valid); end
      checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", tag_err); end
      for (int i = 0; i < 4; i++) step();
      checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b want 1", tag_err); end
   endtask

   task automatic test_reset_midstream();
      m_pc[0] = $urandom;
      m_tm[0] = NT'($urandom);
      icache_req_ready = 1'b1;
      ifetch_ready = 1'b0;
      offer(2'd0, m_pc[0], m_tm[0]);
      step();
      sched_valid = 1'b0;
      step();
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd0;
      icache_rsp_data = $urandom;
      step();
      icache_rsp_valid = 1'b0;
      icache_req_ready = 1'b0;
      offer(2'd1, 32'h8000_0010, 4'h3);
      step();
      offer(2'd2, 32'h8000_0020, 4'h5);
      step();
      sched_valid = 1'b0;
      checks++; if ({icache_req_valid, ifetch_valid, pending_mask} !== {1'b1, 1'b1, 4'b0110}) begin errors++; $display("FAIL mid_pre: got reqv=%b ifv=%b pend=%b want 1/1/0110", icache_req_valid, ifetch_valid, pending_mask); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({sched_ready, icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready} !== '0) begin errors++; $display("FAIL mid_req_zero: got sr=%b v=%b a=%h t=%0d rr=%b want all 0", sched_ready, icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready); end
      checks++; if ({ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr} !== '0) begin errors++; $display("FAIL mid_ifetch_zero: got v=%b w=%0d pc=%h tm=%h i=%h want all 0", ifetch_valid, ifetch_wid, ifetch_pc, ifetch_tmask, ifetch_instr); end
      checks++; if ({pending_mask, tag_err} !== '0) begin errors++; $display("FAIL mid_state_zero: got pend=%b err=%b want 0000/0", pending_mask, tag_err); end
      step();
      reset = 1'b0;
      ifetch_ready = 1'b1;
      icache_rsp_valid = 1'b1;
      icache_rsp_tag = 2'd1;
      icache_rsp_data = 32'h0000_0013;
      step();
      icache_rsp_valid = 1'b0;
      checks++; if (ifetch_valid !== 1'b0 || tag_err !== 1'b1) begin errors++; $display("FAIL mid_stale_rsp: got ifv=%b err=%b want 0/1", ifetch_valid, tag_err); end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_ooo_join();
      test_pending_stall();
      test_ifetch_backpressure();
      test_random(400);
      test_spurious_tag();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
